// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 VGA timing defaults and monitor state encoding
package vga_timing_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [1:0] SEEK_H = 2'd0;
  localparam logic [1:0] SEEK_V = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
endpackage

// File: rtl/vga_mon_ref_counter.sv
// vga_mon_ref_counter: reference h/v position with load/wrap and expected sync/video decode
// Ports: clk, reset (async, active-high), tick (pixel enable), h_load/v_load (align to sync
// edge), hcnt/vcnt (position of the current tick), exp_hsync/exp_vsync/exp_video, frame_last.
module vga_mon_ref_counter #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit SYNC_ACT  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       h_load,
  input  logic       v_load,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       exp_hsync,
  output logic       exp_vsync,
  output logic       exp_video,
  output logic       frame_last
);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  // The registers hold the position of the previous tick; hcnt/vcnt are the current tick.
  always_comb begin
    hcnt = (hcnt_q == H_LAST) ? '0 : hcnt_q + 10'd1;
    vcnt = (hcnt != '0) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    hcnt_d = !tick ? hcnt_q : h_load ? H_SS : hcnt;
    vcnt_d = !tick ? vcnt_q : v_load ? V_SS : vcnt;
    exp_hsync = ((hcnt >= H_SS) && (hcnt <= H_SE)) ? SYNC_ACT : !SYNC_ACT;
    exp_vsync = ((vcnt >= V_SS) && (vcnt <= V_SE)) ? SYNC_ACT : !SYNC_ACT;
    exp_video = (hcnt < H_VIS) && (vcnt < V_VIS);
    frame_last = (hcnt == H_LAST) && (vcnt == V_LAST);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: locks to incoming VGA sync edges and checks every pixel tick against reference timing
// Ports: clk, reset (async, active-high), p_tick, hsync/vsync/video_on/pixel_x/pixel_y under test,
// clear_err; locked, frame_done, sticky err_hsync/err_vsync/err_video/err_pixel, frame_count, err_count.
// Define VGA_MON_COORD_CHECK_EN to also check pixel_x/pixel_y during the visible area.
module vga_sync_monitor import vga_timing_pkg::*; #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit SYNC_ACT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        clear_err,
  output logic        locked,
  output logic        frame_done,
  output logic        err_hsync,
  output logic        err_vsync,
  output logic        err_video,
  output logic        err_pixel,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);
  logic [1:0]  state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d, err_count_q, err_count_d, err_base;
  logic        err_hsync_q, err_hsync_d, err_vsync_q, err_vsync_d;
  logic        err_video_q, err_video_d, err_pixel_q, err_pixel_d;
  logic [9:0]  hcnt, vcnt;
  logic        exp_hsync, exp_vsync, exp_video, frame_last;
  logic        hs_edge, vs_edge, chk, h_load, v_load;
  logic        mis_h, mis_v, mis_vid, mis_pix, any_err;
  vga_mon_ref_counter #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_ACT(SYNC_ACT)
  ) u_ref (
    .clk(clk), .reset(reset), .tick(p_tick), .h_load(h_load), .v_load(v_load),
    .hcnt(hcnt), .vcnt(vcnt), .exp_hsync(exp_hsync), .exp_vsync(exp_vsync),
    .exp_video(exp_video), .frame_last(frame_last)
  );
`ifdef VGA_MON_COORD_CHECK_EN
  assign mis_pix = chk && exp_video && ((pixel_x != hcnt) || (pixel_y != vcnt));
`else
  logic unused_pix;
  assign unused_pix = ^{pixel_x, pixel_y};
  assign mis_pix = 1'b0;
`endif
  always_comb begin
    hs_edge = (hs_prev_q != SYNC_ACT) && (hsync == SYNC_ACT);
    vs_edge = (vs_prev_q != SYNC_ACT) && (vsync == SYNC_ACT);
    chk = p_tick && (state_q == LOCKED);
    mis_h = chk && (hsync != exp_hsync);
    mis_v = chk && (vsync != exp_vsync);
    mis_vid = chk && (video_on != exp_video);
    any_err = mis_h || mis_v || mis_vid || mis_pix;
    h_load = p_tick && (state_q == SEEK_H) && hs_edge;
    v_load = p_tick && (state_q == SEEK_V) && vs_edge && (hcnt == '0);
    // A vsync edge off line start means the h alignment was false; start over. Unused codes recover to SEEK_H.
    state_d = !p_tick ? state_q :
              (state_q == SEEK_H) ? (hs_edge ? SEEK_V : SEEK_H) :
              (state_q == SEEK_V) ? (!vs_edge ? SEEK_V : (hcnt == '0) ? LOCKED : SEEK_H) :
              ((state_q == LOCKED) && !mis_h && !mis_v) ? LOCKED : SEEK_H;
    hs_prev_d = p_tick ? hsync : hs_prev_q;
    vs_prev_d = p_tick ? vsync : vs_prev_q;
    frame_done_d = chk && frame_last;
    frame_count_d = frame_count_q + 16'(frame_done_d);
    // A new error on the clearing clk survives the clear.
    err_hsync_d = mis_h || (err_hsync_q && !clear_err);
    err_vsync_d = mis_v || (err_vsync_q && !clear_err);
    err_video_d = mis_vid || (err_video_q && !clear_err);
    err_pixel_d = mis_pix || (err_pixel_q && !clear_err);
    err_base = clear_err ? '0 : err_count_q;
    err_count_d = (any_err && (err_base != 16'hFFFF)) ? err_base + 16'd1 : err_base;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= SEEK_H;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      err_hsync_q   <= 1'b0;
      err_vsync_q   <= 1'b0;
      err_video_q   <= 1'b0;
      err_pixel_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      err_hsync_q   <= err_hsync_d;
      err_vsync_q   <= err_vsync_d;
      err_video_q   <= err_video_d;
      err_pixel_q   <= err_pixel_d;
    end
  assign locked      = (state_q == LOCKED);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign err_hsync   = err_hsync_q;
  assign err_vsync   = err_vsync_q;
  assign err_video   = err_video_q;
  assign err_pixel   = err_pixel_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of the sync monitor against a scaled-down vga_sync timing generator
module tb_vga_sync_monitor;
  localparam int HD = 16, HF = 4, HS = 6, HB = 4, VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB, VT = VD + VF + VS + VB;
  localparam int LIMIT = 6000;
  logic clk = 1'b0, reset = 1'b1, clear_err = 1'b0;
  logic ptog, fast = 1'b0, p_tick;
  logic hs_flip = 1'b0, vid_inv = 1'b0, x_flip = 1'b0;
  logic [9:0] gx, gy, pixel_x, pixel_y;
  logic hsync, vsync, video_on;
  logic locked, frame_done, err_hsync, err_vsync, err_video, err_pixel;
  logic [15:0] frame_count, err_count;
  int n_tests = 0, n_fail = 0, fc;
  logic exp_pix;
  always #10 clk = !clk;
  assign p_tick = fast | ptog;
  always @(posedge clk or posedge reset)
    if (reset) begin
      gx <= '0;
      gy <= '0;
      ptog <= 1'b0;
    end else begin
      ptog <= !ptog;
      if (p_tick) begin
        gx <= (gx == 10'(HT - 1)) ? '0 : gx + 10'd1;
        if (gx == 10'(HT - 1)) gy <= (gy == 10'(VT - 1)) ? '0 : gy + 10'd1;
      end
    end
  assign hsync    = ((gx >= 10'(HD + HF)) && (gx < 10'(HD + HF + HS))) ^ hs_flip;
  assign vsync    = (gy >= 10'(VD + VF)) && (gy < 10'(VD + VF + VS));
  assign video_on = ((gx < 10'(HD)) && (gy < 10'(VD))) ^ vid_inv;
  assign pixel_x  = gx ^ {9'd0, x_flip};
  assign pixel_y  = gy;
  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .clear_err(clear_err),
    .locked(locked), .frame_done(frame_done), .err_hsync(err_hsync), .err_vsync(err_vsync),
    .err_video(err_video), .err_pixel(err_pixel), .frame_count(frame_count), .err_count(err_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_pos(input string tag, input int x, input int y);
    int n = 0;
    while (!(gx == 10'(x) && gy == 10'(y) && p_tick) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < LIMIT, 1);
  endtask
  task automatic wait_lock(input string tag);
    int n = 0;
    while (!locked && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, locked, 1);
  endtask
  task automatic wait_frame(input string tag);
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, frame_done, 1);
  endtask
  function automatic logic [37:0] outs();
    return {locked, frame_done, err_hsync, err_vsync, err_video, err_pixel, frame_count, err_count};
  endfunction
  initial begin
`ifdef VGA_MON_COORD_CHECK_EN
    exp_pix = 1'b1;
`else
    exp_pix = 1'b0;
`endif
    #250;
    check("reset_outs", 32'(outs()), 0);
    check("reset_hi", 32'(outs() >> 32), 0);
    #250;
    reset = 1'b0;
    wait_lock("lock_wait");
    check("lock_line", gy, VD + VF);
    check("lock_fc", frame_count, 0);
    wait_frame("frame1");
    @(negedge clk);
    check("frame_pulse_1clk", frame_done, 0);
    wait_frame("frame2");
    wait_frame("frame3");
    check("clean_fc", frame_count, 3);
    check("clean_errs", {err_hsync, err_vsync, err_video, err_pixel}, 0);
    check("clean_errcnt", err_count, 0);
    wait_pos("pos_hs", HD + HF + 2, 5);
    hs_flip = 1'b1;
    @(negedge clk);
    hs_flip = 1'b0;
    check("hs_flag", err_hsync, 1);
    check("hs_count", err_count, 1);
    check("hs_unlock", locked, 0);
    check("hs_other", {err_vsync, err_video, err_pixel}, 0);
    wait_lock("hs_relock");
    fc = frame_count;
    wait_frame("hs_frame");
    check("hs_fc_resume", frame_count, 32'(fc + 1));
    check("hs_count_hold", err_count, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clr_flags", {err_hsync, err_vsync, err_video, err_pixel}, 0);
    check("clr_count", err_count, 0);
    check("clr_fc", frame_count, 32'(fc + 1));
    check("clr_lock", locked, 1);
    wait_pos("pos_pix", 8, 6);
    x_flip = 1'b1;
    @(negedge clk);
    x_flip = 1'b0;
    check("pix_flag", err_pixel, exp_pix);
    check("pix_count", err_count, 32'(exp_pix));
    check("pix_lock", locked, 1);
    check("pix_other", {err_hsync, err_vsync, err_video}, 0);
    wait_pos("pos_clrerr", 3, 3);
    vid_inv = 1'b1;
    clear_err = 1'b1;
    @(negedge clk);
    vid_inv = 1'b0;
    clear_err = 1'b0;
    check("clrerr_video", err_video, 1);
    check("clrerr_pixel", err_pixel, 0);
    check("clrerr_count", err_count, 1);
    check("clrerr_lock", locked, 1);
    wait_pos("pos_rst", 0, 9);
    reset = 1'b1;
    #50;
    check("midrst_outs", 32'(outs()), 0);
    check("midrst_hi", 32'(outs() >> 32), 0);
    #50;
    reset = 1'b0;
    wait_lock("rst_relock");
    wait_frame("rst_frame");
    check("rst_fc", frame_count, 1);
    check("rst_errs", {err_hsync, err_vsync, err_video, err_pixel}, 0);
    check("rst_errcnt", err_count, 0);
    fast = 1'b1;
    vid_inv = 1'b1;
    repeat (65600) @(negedge clk);
    check("sat_count", err_count, 16'hFFFF);
    check("sat_lock", locked, 1);
    check("sat_video", err_video, 1);
    check("sat_sync", {err_hsync, err_vsync}, 0);
    @(negedge clk);
    check("sat_hold", err_count, 16'hFFFF);
    vid_inv = 1'b0;
    fast = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
